// File: rtl/micro_sequencer.sv
// Next-state generator and state register for the microprogrammed control unit.
// Selects the next state from the control word's sequencing fields, with a bounded MOC wait.
module micro_sequencer #(
    parameter int STATE_W     = 7,
    parameter int NUM_STATES  = 45,
    parameter int RESET_STATE = 0,
    parameter int FETCH_STATE = 1,
    parameter int MOC_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2:0]         next_sel,
    input  logic [1:0]         cond_sel,
    input  logic               cond_inv,
    input  logic [STATE_W-1:0] cr_addr,
    input  logic               moc,
    input  logic [2:0]         cond_in,
    input  logic [STATE_W-1:0] dispatch_state,
    output logic [STATE_W-1:0] current_state,
    output logic               waiting,
    output logic               mem_fault,
    output logic               invalid_state
);

    localparam logic [STATE_W-1:0] FETCH    = STATE_W'(FETCH_STATE);
    localparam logic [STATE_W-1:0] RST      = STATE_W'(RESET_STATE);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(MOC_TIMEOUT - 1);
    localparam logic               TO_EN    = (MOC_TIMEOUT != 0);

    localparam logic [2:0] SEL_DISPATCH = 3'b000;
    localparam logic [2:0] SEL_FETCH    = 3'b001;
    localparam logic [2:0] SEL_LITERAL  = 3'b010;
    localparam logic [2:0] SEL_INC      = 3'b011;
    localparam logic [2:0] SEL_BRANCH   = 3'b100;
    localparam logic [2:0] SEL_WAIT     = 3'b101;
    localparam logic [2:0] SEL_CALLRET  = 3'b110;

    function automatic logic out_of_range(input logic [STATE_W-1:0] s);
        return 32'(s) >= NUM_STATES;
    endfunction

    logic               c_raw;
    logic               c;
    logic [STATE_W-1:0] inc;
    logic [STATE_W-1:0] target;
    logic               reserved;
    logic               hold;
    logic               timeout;
    logic               clamp;
    logic [CNT_W-1:0]   wait_cnt;

    always_comb begin
        c_raw = moc;
        case (cond_sel)
            2'b00:   c_raw = moc;
            2'b01:   c_raw = cond_in[0];
            2'b10:   c_raw = cond_in[1];
            default: c_raw = cond_in[2];
        endcase
        c = c_raw ^ cond_inv;
    end

    // Incrementer wraps modulo 2^STATE_W; the wrapped value is range-checked like any target.
    assign inc = current_state + 1'b1;

    always_comb begin
        target   = FETCH;
        reserved = 1'b0;
        case (next_sel)
            SEL_DISPATCH: target = dispatch_state;
            SEL_FETCH:    target = FETCH;
            SEL_LITERAL:  target = cr_addr;
            SEL_INC:      target = inc;
            SEL_BRANCH:   target = c ? cr_addr : inc;
            SEL_WAIT:     target = c ? inc : current_state;
            SEL_CALLRET:  target = c ? cr_addr : FETCH;
            default:      reserved = 1'b1;
        endcase
    end

    assign hold    = (next_sel == SEL_WAIT) && !c;
    assign timeout = hold && TO_EN && (wait_cnt == CNT_LAST);
    assign clamp   = reserved || out_of_range(target);
    assign waiting = hold && !reset;

    // Timeout outranks the clamp so the two fault pulses can never coincide.
    always_ff @(posedge clk) begin
        if (reset) begin
            current_state <= RST;
            wait_cnt      <= '0;
            mem_fault     <= 1'b0;
            invalid_state <= 1'b0;
        end else begin
            mem_fault     <= 1'b0;
            invalid_state <= 1'b0;
            if (timeout) begin
                current_state <= FETCH;
                wait_cnt      <= '0;
                mem_fault     <= 1'b1;
            end else if (clamp) begin
                current_state <= FETCH;
                wait_cnt      <= '0;
                invalid_state <= 1'b1;
            end else begin
                current_state <= target;
                wait_cnt      <= hold ? wait_cnt + 1'b1 : '0;
            end
        end
    end

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer: a behavioural model checked every cycle, plus
// hand-computed literal expectations along the directed scenarios.
module tb_micro_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] next_sel;
    logic [1:0] cond_sel;
    logic       cond_inv;
    logic [6:0] cr_addr;
    logic       moc;
    logic [2:0] cond_in;
    logic [6:0] dispatch_state;
    logic [6:0] current_state;
    logic       waiting;
    logic       mem_fault;
    logic       invalid_state;

    int n_checks = 0;
    int n_errors = 0;
    bit armed = 1'b0;

    // Model state: plain integers driven by the sequencing rules.
    int m_state = 0;
    int m_holds = 0;
    int m_fault = 0;
    int m_inv   = 0;

    micro_sequencer dut (
        .clk(clk), .reset(reset), .next_sel(next_sel), .cond_sel(cond_sel),
        .cond_inv(cond_inv), .cr_addr(cr_addr), .moc(moc), .cond_in(cond_in),
        .dispatch_state(dispatch_state), .current_state(current_state),
        .waiting(waiting), .mem_fault(mem_fault), .invalid_state(invalid_state)
    );

    always #5 clk = ~clk;

    function automatic int cond_now();
        int raw;
        raw = (cond_sel == 2'd0) ? int'(moc) : int'(cond_in[int'(cond_sel) - 1]);
        return raw ^ int'(cond_inv);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        int cc, nxt;
        cc = cond_now();
        m_fault = 0;
        m_inv   = 0;
        if (reset) begin
            m_state = 0;
            m_holds = 0;
        end else if (next_sel == 3'd5 && cc == 0) begin
            if (m_holds + 1 >= 16) begin
                m_state = 1;
                m_holds = 0;
                m_fault = 1;
            end else begin
                m_holds = m_holds + 1;
            end
        end else begin
            m_holds = 0;
            case (next_sel)
                3'd0: nxt = int'(dispatch_state);
                3'd1: nxt = 1;
                3'd2: nxt = int'(cr_addr);
                3'd3: nxt = (m_state + 1) % 128;
                3'd4: nxt = cc ? int'(cr_addr) : (m_state + 1) % 128;
                3'd5: nxt = (m_state + 1) % 128;
                3'd6: nxt = cc ? int'(cr_addr) : 1;
                default: nxt = -1;
            endcase
            if (nxt < 0 || nxt >= 45) begin
                m_state = 1;
                m_inv   = 1;
            end else begin
                m_state = nxt;
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("model_state", int'(current_state), m_state);
            chk("model_mem_fault", int'(mem_fault), m_fault);
            chk("model_invalid", int'(invalid_state), m_inv);
            chk("model_waiting", int'(waiting),
                (next_sel == 3'd5 && cond_now() == 0 && !reset) ? 1 : 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; next_sel = 3'd1; cond_sel = 2'd0; cond_inv = 1'b0;
        cr_addr = 7'd0; moc = 1'b0; cond_in = 3'b000; dispatch_state = 7'd0;
        step();
        armed = 1'b1;
        step();

        reset = 1'b0; next_sel = 3'd2; cr_addr = 7'd12;
        step();
        chk("lit_load_12", int'(current_state), 12);

        // Reset held two cycles from state 12, then fetch.
        reset = 1'b1;
        step();
        step();
        chk("lit_reset_state", int'(current_state), 0);
        chk("lit_reset_fault", int'(mem_fault), 0);
        chk("lit_reset_inv", int'(invalid_state), 0);
        reset = 1'b0; next_sel = 3'd1;
        step();
        chk("lit_fetch", int'(current_state), 1);

        // Dispatch, valid then out of range.
        next_sel = 3'd0; dispatch_state = 7'd7;
        step();
        chk("lit_dispatch_7", int'(current_state), 7);
        dispatch_state = 7'd60;
        step();
        chk("lit_dispatch_clamp", int'(current_state), 1);
        chk("lit_dispatch_inv", int'(invalid_state), 1);
        next_sel = 3'd1;
        step();
        chk("lit_inv_one_cycle", int'(invalid_state), 0);

        // MOC wait completing after three holds.
        next_sel = 3'd5; cond_sel = 2'd0; moc = 1'b0;
        #1 chk("lit_waiting_hi", int'(waiting), 1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("lit_wait_hold", int'(current_state), 1);
        end
        moc = 1'b1;
        #1 chk("lit_waiting_lo", int'(waiting), 0);
        step();
        chk("lit_wait_done", int'(current_state), 2);
        chk("lit_wait_nofault", int'(mem_fault), 0);

        // MOC never arrives: 15 holds then timeout to fetch.
        moc = 1'b0;
        for (int i = 0; i < 15; i++) step();
        chk("lit_timeout_hold", int'(current_state), 2);
        chk("lit_timeout_pre", int'(mem_fault), 0);
        step();
        chk("lit_timeout_state", int'(current_state), 1);
        chk("lit_timeout_fault", int'(mem_fault), 1);
        chk("lit_timeout_noinv", int'(invalid_state), 0);
        // Counter restarted: 15 holds, then success on the would-be timeout cycle.
        for (int i = 0; i < 15; i++) step();
        chk("lit_fault_one_cycle", int'(mem_fault), 0);
        moc = 1'b1;
        step();
        chk("lit_success_wins", int'(current_state), 2);
        chk("lit_success_nofault", int'(mem_fault), 0);

        // Conditional branch on ALU zero, then inverted.
        next_sel = 3'd4; cond_sel = 2'd1; cr_addr = 7'd30; cond_in = 3'b001; cond_inv = 1'b0;
        step();
        chk("lit_branch_taken", int'(current_state), 30);
        cond_inv = 1'b1;
        step();
        chk("lit_branch_inv", int'(current_state), 31);

        // Mode 110 on negative and carry flags.
        next_sel = 3'd6; cond_inv = 1'b0; cond_sel = 2'd2; cond_in = 3'b010; cr_addr = 7'd20;
        step();
        chk("lit_callret_taken", int'(current_state), 20);
        cond_sel = 2'd3; cond_in = 3'b000;
        step();
        chk("lit_callret_fetch", int'(current_state), 1);

        // Incrementer past the last valid state, oversized literal, reserved mode.
        next_sel = 3'd2; cr_addr = 7'd44;
        step();
        next_sel = 3'd3;
        step();
        chk("lit_inc_clamp", int'(current_state), 1);
        chk("lit_inc_clamp_inv", int'(invalid_state), 1);
        next_sel = 3'd2; cr_addr = 7'd127;
        step();
        chk("lit_literal_clamp", int'(current_state), 1);
        next_sel = 3'd7;
        step();
        chk("lit_reserved_state", int'(current_state), 1);
        chk("lit_reserved_inv", int'(invalid_state), 1);

        // Reset on the fifth wait cycle clears the counter.
        next_sel = 3'd2; cr_addr = 7'd9;
        step();
        next_sel = 3'd5; cond_sel = 2'd0; moc = 1'b0;
        for (int i = 0; i < 4; i++) step();
        reset = 1'b1;
        #1 chk("lit_waiting_reset", int'(waiting), 0);
        step();
        chk("lit_wait_reset_state", int'(current_state), 0);
        chk("lit_wait_reset_fault", int'(mem_fault), 0);
        reset = 1'b0;
        for (int i = 0; i < 15; i++) step();
        chk("lit_cnt_cleared", int'(mem_fault), 0);
        step();
        chk("lit_cnt_cleared_fault", int'(mem_fault), 1);

        next_sel = 3'd1;
        step();
        step();
        armed = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
